// File: rtl/ca_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding, PC step and
// the word-alignment helper used for branch redirects.
package ca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and
// keeps a one-entry output buffer that reads as a NOP bubble when empty.
module fetch_unit
    import ca_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        instValid,
    output logic [31:0] pcOut,
    output logic [31:0] instOut
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  req_addr_r;
    logic         valid_r;
    logic [31:0]  inst_r;
    logic [31:0]  pc_plus4_r;

    logic         consume_s;
    logic         can_issue_s;
    logic [31:0]  pc_next_s;
    logic         req_s;
    logic [31:0]  addr_s;

    assign consume_s   = valid_r && !freeze;
    assign can_issue_s = !rst && !branchTaken && (!valid_r || !freeze);
    assign pc_next_s   = pc_r + PC_INC;

    // Request and address seen by memory; held stable while a transfer is outstanding.
    always_comb begin
        req_s  = 1'b0;
        addr_s = pc_r;
        if (rst) begin
            req_s  = 1'b0;
            addr_s = RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    req_s  = can_issue_s;
                    addr_s = pc_r;
                end
                WAIT, DROP: begin
                    req_s  = 1'b1;
                    addr_s = req_addr_r;
                end
                default: begin
                    req_s  = 1'b0;
                    addr_s = pc_r;
                end
            endcase
        end
    end

    assign imemReq   = req_s;
    assign imemAddr  = addr_s;
    assign instValid = valid_r;
    assign instOut   = inst_r;
    assign pcOut     = pc_plus4_r;

    // Fetch FSM, PC and output buffer. The buffer payload is zeroed whenever it
    // empties so instOut/pcOut read as NOP/0 straight from the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            valid_r    <= 1'b0;
            inst_r     <= NOP_INST;
            pc_plus4_r <= 32'h0000_0000;
        end else if (branchTaken) begin
            pc_r       <= word_align(branchAddr);
            valid_r    <= 1'b0;
            inst_r     <= NOP_INST;
            pc_plus4_r <= 32'h0000_0000;
            case (state_r)
                IDLE:    state_r <= IDLE;
                WAIT:    state_r <= imemReady ? IDLE : DROP;
                DROP:    state_r <= DROP;
                default: state_r <= IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (can_issue_s) begin
                        req_addr_r <= pc_r;
                        if (imemReady) begin
                            valid_r    <= 1'b1;
                            inst_r     <= imemData;
                            pc_plus4_r <= pc_next_s;
                            pc_r       <= pc_next_s;
                        end else begin
                            state_r <= WAIT;
                            if (consume_s) begin
                                valid_r    <= 1'b0;
                                inst_r     <= NOP_INST;
                                pc_plus4_r <= 32'h0000_0000;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (imemReady) begin
                        valid_r    <= 1'b1;
                        inst_r     <= imemData;
                        pc_plus4_r <= pc_next_s;
                        pc_r       <= pc_next_s;
                        state_r    <= IDLE;
                    end else if (consume_s) begin
                        valid_r    <= 1'b0;
                        inst_r     <= NOP_INST;
                        pc_plus4_r <= 32'h0000_0000;
                    end
                end
                DROP: begin
                    // Squashed transfer: the late word is thrown away.
                    if (imemReady) begin
                        state_r <= IDLE;
                    end
                    if (consume_s) begin
                        valid_r    <= 1'b0;
                        inst_r     <= NOP_INST;
                        pc_plus4_r <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    valid_r    <= 1'b0;
                    inst_r     <= NOP_INST;
                    pc_plus4_r <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wait states, freeze, branch
// squash, branch+freeze, PC wrap and reset during an outstanding fetch.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic        instValid;
    logic [31:0] pcOut;
    logic [31:0] instOut;

    int n_checked;
    int n_failed;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemData    (imemData),
        .instValid   (instValid),
        .pcOut       (pcOut),
        .instOut     (instOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imemData = mem_word(imemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checked++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = 32'h0000_0000;
        imemReady   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checked = 0;
        n_failed  = 0;

        // Reset state
        do_reset();
        #1;
        check("rst_req",   {31'h0, imemReq},   32'h0);
        check("rst_addr",  imemAddr,           32'h0);
        check("rst_valid", {31'h0, instValid}, 32'h0);
        check("rst_pcout", pcOut,              32'h0);
        check("rst_inst",  instOut,            32'h0);

        // Streaming with zero-wait memory
        rst       = 1'b0;
        imemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            check("str_req",  {31'h0, imemReq}, 32'h1);
            check("str_addr", imemAddr, 32'(4 * i));
            if (i == 0) begin
                check("str_first_valid", {31'h0, instValid}, 32'h0);
                check("str_first_inst",  instOut,            32'h0);
            end else begin
                check("str_valid", {31'h0, instValid}, 32'h1);
                check("str_inst",  instOut, mem_word(32'(4 * (i - 1))));
                check("str_pcout", pcOut,   32'(4 * i));
            end
        end

        // Three wait states on the first fetch
        do_reset();
        rst       = 1'b0;
        imemReady = 1'b0;
        #1;
        check("ws_req0",  {31'h0, imemReq}, 32'h1);
        check("ws_addr0", imemAddr, 32'h0);
        for (int k = 1; k < 3; k++) begin
            tick();
            #1;
            check("ws_req",   {31'h0, imemReq},   32'h1);
            check("ws_addr",  imemAddr,           32'h0);
            check("ws_valid", {31'h0, instValid}, 32'h0);
        end
        tick();
        imemReady = 1'b1;
        #1;
        check("ws_req3",  {31'h0, imemReq}, 32'h1);
        check("ws_addr3", imemAddr, 32'h0);
        tick();
        imemReady = 1'b0;
        #1;
        check("ws_valid_fill", {31'h0, instValid}, 32'h1);
        check("ws_inst_fill",  instOut, mem_word(32'h0));
        check("ws_pcout_fill", pcOut,   32'h4);
        check("ws_addr_next",  imemAddr, 32'h4);

        // Freeze with inst@8 buffered
        do_reset();
        rst       = 1'b0;
        imemReady = 1'b1;
        tick();
        tick();
        tick();
        freeze = 1'b1;
        #1;
        check("frz_inst0",  instOut, mem_word(32'h8));
        check("frz_pcout0", pcOut,   32'hC);
        check("frz_req0",   {31'h0, imemReq}, 32'h0);
        tick();
        #1;
        check("frz_inst1",  instOut, mem_word(32'h8));
        check("frz_pcout1", pcOut,   32'hC);
        check("frz_req1",   {31'h0, imemReq}, 32'h0);
        tick();
        freeze = 1'b0;
        #1;
        check("frz_inst2",  instOut, mem_word(32'h8));
        check("frz_req2",   {31'h0, imemReq}, 32'h1);
        check("frz_addr2",  imemAddr, 32'hC);
        tick();
        #1;
        check("frz_inst_after",  instOut, mem_word(32'hC));
        check("frz_pcout_after", pcOut,   32'h10);

        // Branch while the fetch of 0x10 is waiting
        do_reset();
        rst       = 1'b0;
        imemReady = 1'b1;
        tick();
        tick();
        tick();
        tick();
        imemReady = 1'b0;
        #1;
        check("br_addr_pend", imemAddr, 32'h10);
        check("br_inst12",    instOut,  mem_word(32'hC));
        tick();
        #1;
        check("br_wait_valid", {31'h0, instValid}, 32'h0);
        branchTaken = 1'b1;
        branchAddr  = 32'h0000_0103;
        #1;
        check("br_wait_req",  {31'h0, imemReq}, 32'h1);
        check("br_wait_addr", imemAddr, 32'h10);
        tick();
        branchTaken = 1'b0;
        #1;
        check("br_drop_valid", {31'h0, instValid}, 32'h0);
        check("br_drop_req",   {31'h0, imemReq},   32'h1);
        check("br_drop_addr",  imemAddr,           32'h10);
        tick();
        imemReady = 1'b1;
        #1;
        check("br_late_addr", imemAddr, 32'h10);
        tick();
        #1;
        check("br_discard_valid", {31'h0, instValid}, 32'h0);
        check("br_target_addr",   imemAddr,           32'h100);
        tick();
        #1;
        check("br_target_valid", {31'h0, instValid}, 32'h1);
        check("br_target_inst",  instOut, mem_word(32'h100));
        check("br_target_pcout", pcOut,   32'h104);

        // Branch and freeze in the same cycle
        do_reset();
        rst       = 1'b0;
        imemReady = 1'b1;
        tick();
        tick();
        freeze      = 1'b1;
        branchTaken = 1'b1;
        branchAddr  = 32'h0000_0040;
        #1;
        check("bf_inst_before", instOut, mem_word(32'h4));
        check("bf_req",         {31'h0, imemReq}, 32'h0);
        tick();
        freeze      = 1'b0;
        branchTaken = 1'b0;
        #1;
        check("bf_valid", {31'h0, instValid}, 32'h0);
        check("bf_inst",  instOut,  32'h0);
        check("bf_pcout", pcOut,    32'h0);
        check("bf_addr",  imemAddr, 32'h40);
        tick();
        #1;
        check("bf_target_inst",  instOut, mem_word(32'h40));
        check("bf_target_pcout", pcOut,   32'h44);

        // PC wrap at the top of the address space
        do_reset();
        rst         = 1'b0;
        imemReady   = 1'b1;
        branchTaken = 1'b1;
        branchAddr  = 32'hFFFF_FFFC;
        #1;
        check("wr_br_req", {31'h0, imemReq}, 32'h0);
        tick();
        branchTaken = 1'b0;
        #1;
        check("wr_addr_top", imemAddr, 32'hFFFF_FFFC);
        tick();
        imemReady = 1'b0;
        #1;
        check("wr_valid",   {31'h0, instValid}, 32'h1);
        check("wr_inst",    instOut,  mem_word(32'hFFFF_FFFC));
        check("wr_pcout",   pcOut,    32'h0);
        check("wr_addr_0",  imemAddr, 32'h0);

        // Reset while the fetch of 0x0 is waiting
        tick();
        #1;
        check("mr_wait_req", {31'h0, imemReq}, 32'h1);
        rst = 1'b1;
        #1;
        check("mr_rst_req", {31'h0, imemReq}, 32'h0);
        tick();
        #1;
        check("mr_req",   {31'h0, imemReq},   32'h0);
        check("mr_addr",  imemAddr,           32'h0);
        check("mr_valid", {31'h0, instValid}, 32'h0);
        check("mr_pcout", pcOut,              32'h0);
        check("mr_inst",  instOut,            32'h0);
        rst = 1'b0;
        #1;
        check("mr_restart_req",  {31'h0, imemReq}, 32'h1);
        check("mr_restart_addr", imemAddr,         32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the PC, issues word requests to instruction memory over a req/ready handshake, and holds the returned word in a one-entry output buffer. That buffer survives downstream freezes and presents a NOP bubble whenever no instruction is ready. Taken branches from EXE redirect the PC and squash any in-flight or buffered fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset; low two bits must be 0.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  downstream cannot accept this cycle; this is the IF/ID freeze.
- branchTaken  in  1  redirect request from EXE; also drives IF/ID flush.
- branchAddr  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- imemReq  out  1  fetch request.
- imemAddr  out  32  word-aligned fetch address.
- imemReady  in  1  memory has completed the transfer; imemData is valid this cycle.
- imemData  in  32  returned instruction word.
- instValid  out  1  buffer holds a real instruction.
- pcOut  out  32  PC+4 of the buffered instruction, or 0 when empty.
- instOut  out  32  buffered instruction, or 32'h0 (NOP) when empty.

## Operation
- Registers:
  - pc: next fetch address.
  - reqAddr: address of the outstanding request.
  - buffer: valid, inst, pcPlus4.
  - FSM state.
- Consume: `consume = instValid && !freeze`. On consume the buffer empties unless it is refilled in the same cycle.
- Issue condition: `canIssue = !rst && !branchTaken && (!instValid || !freeze)`. At most one request is outstanding.
- FSM states are IDLE, WAIT and DROP. Reset goes to IDLE.
- IDLE:
  - Drives imemReq = canIssue and imemAddr = pc. reqAddr is loaded with pc on issue.
  - req && ready: buffer <= {1, imemData, pc+4}, pc <= pc+4, stay in IDLE.
  - req && !ready: go to WAIT.
- WAIT:
  - Drives imemReq = 1 and imemAddr = reqAddr. Both must remain stable until ready.
  - ready: fill the buffer, pc <= pc+4, go to IDLE.
- DROP:
  - Request was squashed; imemReq = 1 and imemAddr = reqAddr are still held.
  - ready: discard the data, leave the buffer untouched, go to IDLE.
- Branch (highest priority, overrides freeze):
  - pc <= {branchAddr[31:2], 2'b00} and buffer.valid <= 0.
  - IDLE: no request this cycle.
  - WAIT with ready in the same cycle: discard the data, go to IDLE.
  - WAIT without ready: go to DROP.
  - DROP: stay in DROP with the new pc.
- Freeze with a full buffer: no new issue. An outstanding request may still complete only if the buffer is empty, which the issue rule guarantees.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Reset values:
  - imemReq = 0, imemAddr = RESET_PC.
  - instValid = 0, pcOut = 0, instOut = 0.
  - pc = RESET_PC, state = IDLE.
  - Reset asserted mid-WAIT abandons the transfer. The memory must tolerate imemReq dropping under rst.

## Timing
- Zero-wait memory (ready in the issue cycle): word at A is requested in cycle n; instOut = word and pcOut = A+4 in cycle n+1. Throughput is 1 instruction/cycle.
- k wait cycles: the result appears k cycles later. Between fetches imemReq stays high.
- Freeze in cycle n: instOut and pcOut hold in n+1. No request is issued in n if the buffer is full.
- Branch in cycle n:
  - Buffer is empty (NOP) in n+1.
  - With an idle, zero-wait memory, the first request to the target is issued in n+1 and its word is visible in n+2.
- The IF/ID register samples pcOut and instOut combinationally from the buffer. No extra stage is added.

## Structure
- Shared package ca_pkg holds:
  - fetch_state_t {IDLE, WAIT, DROP}
  - NOP_INST = 32'h0
  - PC_INC = 32'd4
  - a word-align helper function
- Single module. No sub-module: the buffer and FSM are too small to split.

## Test plan
- Reset and streaming, zero-wait memory, RESET_PC=0: release rst and hold ready=1. Expect imemAddr 0,4,8,… each cycle. In the cycle after each issue, instOut = mem[addr] and pcOut = addr+4. In the first post-reset cycle instValid=0 and instOut=0.
- Wait states: ready asserted 3 cycles after req. Expect imemReq high and imemAddr stable for 3 cycles, then the buffer fills with pcOut = 4 and imemAddr advances to 4.
- Freeze: buffer holds inst@8 and freeze is held 2 cycles. Expect instOut and pcOut (12) unchanged and imemReq=0 throughout. After release, inst@12 follows on the next cycle.
- Branch during WAIT: request to 0x10 is outstanding and branchTaken=1 with branchAddr=0x103 (misaligned).
  - Expect instValid=0 next cycle and state DROP.
  - The late word from 0x10 is discarded.
  - The next request goes to 0x100, and pcOut = 0x104.
- Branch plus freeze in the same cycle: expect the buffer flushed (instOut=0) and pc=target. Freeze must not hold the stale instruction.
- Wrap and mid-fetch reset:
  - branchAddr = 0xFFFF_FFFC: the fetch after it goes to 0x0 and pcOut = 0x0 for that word.
  - Assert rst during WAIT: imemReq=0 and all outputs 0 in the next cycle.
